// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program store streaming words into the instruction queue; FETCH_STALL_CNT_EN adds stall_cnt
module instr_fetch_unit #(
    parameter int DATAWIDTH  = 32,
    parameter int PROG_DEPTH = 16,
    localparam int AW        = $clog2(PROG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [DATAWIDTH-1:0] prog_wdata,
    input  logic                 start,
    input  logic [AW:0]          num_instr,
    output logic [DATAWIDTH-1:0] instr,
    output logic                 instr_valid,
    input  logic                 IQ_FULL,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [AW:0]   DEPTH_N = (AW+1)'(PROG_DEPTH);
    localparam logic [AW:0]   ONE_N   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PC  = AW'(1);

    state_t                 state, state_nxt;
    logic [DATAWIDTH-1:0]   mem [PROG_DEPTH];
    logic [AW:0]            count_n;
    logic [AW:0]            issued;
    logic                   start_acc;
    logic                   consume;
    logic                   load;
    logic                   last_load;

    assign start_acc = start && (state == IDLE);
    assign consume   = instr_valid && !IQ_FULL;
    // The transition to DRAIN happens on the last load, so RUN always has words left.
    assign load      = (state == RUN) && (!instr_valid || !IQ_FULL);
    assign last_load = load && ((issued + ONE_N) == count_n);

    // Store contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE))
            mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_instr == '0) ? DONE : RUN;
            RUN:     if (last_load) state_nxt = DRAIN;
            DRAIN:   if (consume) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            issued      <= '0;
            count_n     <= '0;
        end else if (start_acc) begin
            pc      <= '0;
            issued  <= '0;
            count_n <= (num_instr > DEPTH_N) ? DEPTH_N : num_instr;
        end else if (load) begin
            instr       <= mem[pc];
            instr_valid <= 1'b1;
            pc          <= pc + ONE_PC;
            issued      <= issued + ONE_N;
        end else if ((state == DRAIN) && consume) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (start_acc)
            stall_cnt <= '0;
        else if (instr_valid && IQ_FULL && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed table-driven bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_wdata = '0;
    logic          start = 1'b0;
    logic [AW:0]   num_instr = '0;
    logic          IQ_FULL = 1'b0;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    instr_fetch_unit #(.DATAWIDTH(DW), .PROG_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .num_instr(num_instr),
        .instr(instr), .instr_valid(instr_valid), .IQ_FULL(IQ_FULL),
        .busy(busy), .done(done), .pc(pc)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic [4:0]    num;
        logic          full;
        logic          v;
        logic [31:0]   ins;
        logic          d;
        logic          b;
        logic [3:0]    pcv;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] prog [16];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic st, logic [4:0] num, logic full, logic v,
                                logic [31:0] ins, logic d, logic b, logic [3:0] pcv);
        vec_t r;
        r.st = st; r.num = num; r.full = full; r.v = v;
        r.ins = ins; r.d = d; r.b = b; r.pcv = pcv;
        return r;
    endfunction

    task automatic run_rows(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start = vecs[i].st;
            num_instr = vecs[i].num;
            IQ_FULL = vecs[i].full;
            tick();
            start = 1'b0;
            check($sformatf("%s row%0d valid", tag, i - lo), 32'(instr_valid), 32'(vecs[i].v));
            if (vecs[i].v)
                check($sformatf("%s row%0d instr", tag, i - lo), instr, vecs[i].ins);
            check($sformatf("%s row%0d done", tag, i - lo), 32'(done), 32'(vecs[i].d));
            check($sformatf("%s row%0d busy", tag, i - lo), 32'(busy), 32'(vecs[i].b));
            check($sformatf("%s row%0d pc", tag, i - lo), 32'(pc), 32'(vecs[i].pcv));
        end
        IQ_FULL = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        start = 1'b1;
        num_instr = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int got;
        int dn;
        int seen;

        prog[0] = 32'h00012183; prog[1] = 32'h0241C133; prog[2] = 32'h026280B3;
        prog[3] = 32'h008381B3; prog[4] = 32'h023080B3; prog[5] = 32'h40508233;
        prog[6] = 32'h002200B3;
        for (int i = 7; i < 16; i++) prog[i] = 32'h0A000000 | i;

        // Test 1: uninterrupted 7-word stream
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 7, 0, 1, prog[i], 0, 1, 4'(i + 1)));
        vecs.push_back(mk(0, 7, 0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(0, 7, 0, 0, 0, 0, 0, 7));
        // Test 2: three stall cycles on the third word
        vecs.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 7, 0, 1, prog[i], 0, 1, 4'(i + 1)));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 7, 1, 1, prog[2], 0, 1, 3));
        for (int i = 3; i < 7; i++) vecs.push_back(mk(0, 7, 0, 1, prog[i], 0, 1, 4'(i + 1)));
        vecs.push_back(mk(0, 7, 0, 0, 0, 1, 1, 7));
        vecs.push_back(mk(0, 7, 0, 0, 0, 0, 0, 7));
        // Test 3: zero-length start
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        #1;
        check("reset instr", instr, 0);
        check("reset valid", 32'(instr_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset pc", 32'(pc), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i];
            tick();
        end
        prog_we = 1'b0;

        run_rows("t1", 0, 9);
        run_rows("t2", 10, 22);
`ifdef FETCH_STALL_CNT_EN
        check("t2 stall_cnt", 32'(stall_cnt), 3);
`endif
        run_rows("t3", 23, 24);

        // Test 4: count clamps to store depth; mid-stream start ignored
        pulse_start(20);
        got = 0; dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin start = 1'b1; num_instr = 3; end
            tick();
            start = 1'b0;
            if (instr_valid) begin
                if (got < 16) check($sformatf("t4 word%0d", got), instr, prog[got]);
                got++;
            end
            if (done) dn++;
        end
        check("t4 count", 32'(got), 16);
        check("t4 done pulses", 32'(dn), 1);
        check("t4 pc", 32'(pc), 0);
        check("t4 busy", 32'(busy), 0);

        // Test 5: asynchronous reset mid-stream, then full restart
        pulse_start(7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5 pre word%0d", i), instr, prog[i]);
        end
        #2 reset = 1'b0;
        #1;
        check("t5 async instr", instr, 0);
        check("t5 async valid", 32'(instr_valid), 0);
        check("t5 async busy", 32'(busy), 0);
        check("t5 async pc", 32'(pc), 0);
        @(negedge clk);
        reset = 1'b1;
        pulse_start(7);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t5 word%0d", i), instr, prog[i]);
            check($sformatf("t5 valid%0d", i), 32'(instr_valid), 1);
        end
        tick();
        check("t5 done", 32'(done), 1);
        tick();
        check("t5 busy", 32'(busy), 0);

        // Test 6: store write while busy is dropped
        pulse_start(7);
        tick();
        prog_we = 1'b1; prog_addr = 0; prog_wdata = 32'hDEADBEEF;
        tick();
        prog_we = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) begin seen = 1; break; end
        end
        check("t6 done seen", 32'(seen), 1);
        tick();
        check("t6 idle", 32'(busy), 0);
        pulse_start(1);
        tick();
        check("t6 valid", 32'(instr_valid), 1);
        check("t6 entry0", instr, 32'h00012183);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
